// File: rtl/axi_master_pkg.sv
// Shared types and constants for the simple AXI3 master.
package axi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R
    } state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic [2:0] size_from_width(input int unsigned width);
        return 3'($clog2(width / 8));
    endfunction

endpackage

// File: rtl/axi_master_timer.sv
// Response-wait watchdog: down-counter reloaded while idle or on clear, expires at terminal count.
module axi_master_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int unsigned     CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en || clr) begin
            cnt_d = LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry fires on the TIMEOUT-th waiting cycle; the caller gives a handshake priority.
    assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/axi_simple_master.sv
// Single-outstanding AXI3 master: one INCR burst per command, streamed data, one-cycle completion.
module axi_simple_master
    import axi_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [3:0]              cmd_id,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [3:0]              cmd_len,
    input  logic                    wd_valid,
    output logic                    wd_ready,
    input  logic [DATA_WIDTH-1:0]   wd_data,
    input  logic [DATA_WIDTH/8-1:0] wd_strb,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    output logic [1:0]              rd_resp,
    output logic                    done_valid,
    output logic                    done_write,
    output logic [3:0]              done_id,
    output logic [1:0]              done_resp,
    output logic [3:0]              AWID,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic [3:0]              AWLEN,
    output logic [2:0]              AWSIZE,
    output logic [1:0]              AWBURST,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [3:0]              WID,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WLAST,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic [3:0]              BID,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    output logic [3:0]              ARID,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic [3:0]              ARLEN,
    output logic [2:0]              ARSIZE,
    output logic [1:0]              ARBURST,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [3:0]              RID,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RLAST,
    input  logic                    RVALID,
    output logic                    RREADY
);

    localparam logic [2:0] AXSIZE = size_from_width(DATA_WIDTH);

    state_e                  state_q, state_d;
    logic [3:0]              id_q, id_d, len_q, len_d, cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              acc_q, acc_d;
    logic                    err_q, err_d;
    logic                    done_valid_q, done_valid_d, done_write_q, done_write_d;
    logic [3:0]              done_id_q, done_id_d;
    logic [1:0]              done_resp_q, done_resp_d;
    logic                    timer_clr, timer_expire;

    axi_master_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .en     ((state_q == ST_B) || (state_q == ST_R)),
        .clr    (timer_clr),
        .expire (timer_expire)
    );

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        err_d        = err_q;
        done_valid_d = 1'b0;
        done_write_d = done_write_q;
        done_id_d    = done_id_q;
        done_resp_d  = done_resp_q;
        timer_clr    = 1'b0;
        case (state_q)
            ST_IDLE: if (cmd_valid) begin
                id_d    = cmd_id;
                addr_d  = cmd_addr;
                len_d   = cmd_len;
                cnt_d   = 4'd0;
                acc_d   = RESP_OKAY;
                err_d   = 1'b0;
                state_d = cmd_write ? ST_AW : ST_AR;
            end
            ST_AW: if (AWREADY) state_d = ST_W;
            ST_W: if (wd_valid && WREADY) begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == len_q) state_d = ST_B;
            end
            ST_B: begin
                if (BVALID) begin
                    timer_clr    = 1'b1;
                    done_valid_d = 1'b1;
                    done_resp_d  = (BID != id_q) ? RESP_SLVERR : BRESP;
                end else if (timer_expire) begin
                    done_valid_d = 1'b1;
                    done_resp_d  = RESP_DECERR;
                end
                if (done_valid_d) begin
                    done_write_d = 1'b1;
                    done_id_d    = id_q;
                    state_d      = ST_IDLE;
                end
            end
            ST_AR: if (ARREADY) state_d = ST_R;
            ST_R: begin
                if (RVALID && rd_ready) begin
                    timer_clr = 1'b1;
                    cnt_d     = cnt_q + 4'd1;
                    acc_d     = (RRESP > acc_q) ? RRESP : acc_q;
                    // A protocol error anywhere in the burst outranks the slave's own codes.
                    err_d     = err_q || (RID != id_q) || (RLAST && (cnt_q != len_q));
                    if (RLAST) begin
                        done_valid_d = 1'b1;
                        done_resp_d  = err_d ? RESP_SLVERR : acc_d;
                    end
                end else if (timer_expire) begin
                    done_valid_d = 1'b1;
                    done_resp_d  = RESP_DECERR;
                end
                if (done_valid_d) begin
                    done_write_d = 1'b0;
                    done_id_d    = id_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            id_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            acc_q        <= RESP_OKAY;
            err_q        <= 1'b0;
            done_valid_q <= 1'b0;
            done_write_q <= 1'b0;
            done_id_q    <= '0;
            done_resp_q  <= RESP_OKAY;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            err_q        <= err_d;
            done_valid_q <= done_valid_d;
            done_write_q <= done_write_d;
            done_id_q    <= done_id_d;
            done_resp_q  <= done_resp_d;
        end
    end

    assign cmd_ready  = rst && (state_q == ST_IDLE);

    assign AWVALID    = (state_q == ST_AW);
    assign AWID       = id_q;
    assign AWADDR     = addr_q;
    assign AWLEN      = len_q;
    assign AWSIZE     = AXSIZE;
    assign AWBURST    = BURST_INCR;

    assign WVALID     = (state_q == ST_W) && wd_valid;
    assign wd_ready   = (state_q == ST_W) && WREADY;
    assign WID        = id_q;
    assign WDATA      = wd_data;
    assign WSTRB      = wd_strb;
    assign WLAST      = (state_q == ST_W) && (cnt_q == len_q);

    assign BREADY     = (state_q == ST_B);

    assign ARVALID    = (state_q == ST_AR);
    assign ARID       = id_q;
    assign ARADDR     = addr_q;
    assign ARLEN      = len_q;
    assign ARSIZE     = AXSIZE;
    assign ARBURST    = BURST_INCR;

    assign rd_valid   = (state_q == ST_R) && RVALID;
    assign RREADY     = (state_q == ST_R) && rd_ready;
    assign rd_data    = RDATA;
    assign rd_resp    = RRESP;
    assign rd_last    = RLAST;

    assign done_valid = done_valid_q;
    assign done_write = done_write_q;
    assign done_id    = done_id_q;
    assign done_resp  = done_resp_q;

endmodule

// File: doc/axi_simple_master.md
Name: axi_simple_master

Overview:
- Synthesizable AXI3 master: the initiator end of the AXI interface whose responder end the slave VIP driver models.
- Accepts one command at a time (read or write INCR burst) on a simple valid/ready command port and issues it on the AW/W/B or AR/R channels.
- Streams write data in and read data out, and reports a one-cycle completion with response code.
- Sits between test/DUT-side logic and any AXI slave, and serves as the active master opposite the slave VIP.

Parameters:
- ADDR_WIDTH, 32, width of AWADDR/ARADDR/cmd_addr.
- DATA_WIDTH, 32, width of WDATA/RDATA; WSTRB width = DATA_WIDTH/8.
- TIMEOUT, 1024, cycles allowed in B or R state without handshake before abort.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-low reset.
- cmd_valid/cmd_ready  in/out  1/1  command handshake.
- cmd_write  in  1  1=write, 0=read.
- cmd_id  in  4  transaction ID.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_len  in  4  beats-1.
- wd_valid/wd_ready  in/out  1/1  write-data stream handshake.
- wd_data  in  DATA_WIDTH  write-data payload.
- wd_strb  in  DATA_WIDTH/8  write-data strobes.
- rd_valid/rd_ready  out/in  1/1  read-data stream handshake.
- rd_data  out  DATA_WIDTH  read-data payload.
- rd_last  out  1  last read beat.
- rd_resp  out  2  per-beat read response.
- done_valid  out  1  one-cycle completion pulse.
- done_write  out  1  completion is for a write.
- done_id  out  4  completed transaction ID.
- done_resp  out  2  final response of completed transaction.
- AWID AWADDR AWLEN AWSIZE AWBURST AWVALID  out  4/ADDR_WIDTH/4/3/2/1  write address channel.
- AWREADY  in  1  write address ready.
- WID WDATA WSTRB WLAST WVALID  out  4/DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- WREADY  in  1  write data ready.
- BID BRESP BVALID  in  4/2/1  write response channel.
- BREADY  out  1  write response ready.
- ARID ARADDR ARLEN ARSIZE ARBURST ARVALID  out  4/ADDR_WIDTH/4/3/2/1  read address channel.
- ARREADY  in  1  read address ready.
- RID RDATA RRESP RLAST RVALID  in  4/DATA_WIDTH/2/1/1  read data channel.
- RREADY  out  1  read data ready.

Behaviour:
- Interface: single clock clk; reset rst is synchronous, active-low.
- Reset (rst=0 sampled at posedge, including mid-burst):
  - FSM -> IDLE; beat counter and timer cleared.
  - All VALID/READY outputs, done_valid and cmd_ready = 0; address/ID/LEN registers = 0.
  - No completion is reported for an aborted transaction.
- FSM states: IDLE, AW, W, B, AR, R.
- IDLE:
  - cmd_ready=1. On cmd_valid&cmd_ready, register id/addr/len; write -> AW, read -> AR.
  - Command accepted only in IDLE; cmd_ready=0 elsewhere.
- AW:
  - AWVALID=1 with registered fields; AWSIZE=log2(DATA_WIDTH/8); AWBURST=2'b01 (INCR).
  - Fields held stable until AWREADY; on AWVALID&AWREADY -> W.
  - AWVALID asserts the cycle after command acceptance.
- W:
  - WVALID = wd_valid; wd_ready = WREADY; WDATA/WSTRB pass through; WID = registered id.
  - Beat counter starts at 0; WLAST=1 when counter==len.
  - On WVALID&WREADY, counter++; on the last-beat handshake -> B.
  - Outside W: WVALID=0, wd_ready=0.
- B:
  - BREADY=1. On BVALID, capture BRESP, pulse done_valid next cycle with done_write=1, done_id=id -> IDLE.
  - BID != id: done_resp forced to 2'b10 (SLVERR).
- AR: same rules as AW on the AR fields; on handshake -> R.
- R:
  - rd_valid = RVALID; RREADY = rd_ready; rd_data/rd_resp/rd_last pass through RDATA/RRESP/RLAST.
  - Each handshake increments the counter and accumulates the worst response (max of RRESP codes).
  - On the RLAST handshake: done_valid pulse, done_write=0, done_resp = accumulated -> IDLE.
  - RLAST at counter != len, or RID != id: done_resp = 2'b10.
- Timeout:
  - Counter runs in B and R, cleared on any B/R handshake.
  - Reaching TIMEOUT -> done_valid with done_resp=2'b11 (DECERR) -> IDLE.
- Completion: done_valid is exactly one cycle. The next command may be accepted in the cycle done_valid is high, since the FSM is already in IDLE.
- cmd_len=0: single beat, WLAST asserted with the first beat.
- 4 KB crossing: not checked; the issuer is responsible.

Decomposition:
- Package axi_master_pkg:
  - State enum.
  - Constants BURST_INCR=2'b01, RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - Function size_from_width(DATA_WIDTH).
- One sub-module: axi_master_timer (loadable timeout counter with clear/expire), shared by B and R.

Test Plan:
- Write, addr 0x100, len=3, id=5; AWREADY after 2 cycles; data 0xA0..0xA3; BRESP=0 -> AWLEN=3; WLAST only on the 0xA3 beat; done_valid 1 cycle, done_resp=0, done_id=5.
- Read, addr 0x200, len=1; slave returns RRESP 0 then 2 with RLAST -> rd_data matches; done_resp=2.
- Read len=3 with rd_ready toggling every other cycle -> RREADY mirrors rd_ready; no beat lost or duplicated; 4 beats delivered.
- Write with BID=6 vs id=5 -> done_resp=2.
- Read where slave never asserts RVALID, TIMEOUT=16 -> done_resp=3 exactly 16 cycles after entering R; cmd_ready=1 the following cycle.
- rst=0 during W beat 2 of 4 -> next cycle all VALIDs=0, state IDLE, no done_valid; a new len=0 write then completes with done_resp=0.
